pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Consumer of `hazard_detected`: turns hazard, branch-taken and SRAM-wait conditions into per-stage freeze/flush/bubble controls for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
- Stage-control outputs are combinational from the current state and inputs, so they act in the same cycle.
- Sequential logic tracks the SRAM wait state machine, timeouts, consecutive-stall watchdog and saturating performance counters.

Parameters:
- CNT_W, 16, width of each performance counter.
- MAX_STALL, 8, consecutive hazard-stall cycles tolerated before `stall_error` sets.
- MEM_TIMEOUT, 64, MEM_WAIT cycles tolerated before `mem_timeout` sets.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- hazard_detected  input  1  data hazard on the ID-stage instruction (from the hazard detection unit).
- branch_taken  input  1  ID-stage branch resolved taken this cycle.
- mem_req  input  1  MEM-stage instruction is accessing SRAM this cycle.
- mem_ready  input  1  SRAM controller completes the access this cycle.
- cnt_clr  input  1  synchronous clear of the counters and sticky flags.
- freeze_PC  output  1  hold the PC.
- freeze_IF_ID  output  1  hold the IF/ID register.
- flush_IF_ID  output  1  zero the IF/ID register on the next edge.
- bubble_ID_EXE  output  1  load NOP controls into ID/EXE.
- freeze_pipe  output  1  hold PC and all pipeline registers (SRAM wait).
- stall_count  output  CNT_W  cycles with `bubble_ID_EXE`=1.
- flush_count  output  CNT_W  cycles with `flush_IF_ID`=1.
- wait_count  output  CNT_W  cycles with `freeze_pipe`=1.
- stall_error  output  1  sticky: stall watchdog tripped.
- mem_timeout  output  1  sticky: SRAM timeout.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN; all counters, the stall-run counter, the wait counter and both sticky flags = 0.
  - All control outputs forced to 0 while rst_n=0, regardless of inputs.
- States: RUN, MEM_WAIT.
  - RUN, mem_req=1 and mem_ready=0: `freeze_pipe`=1 this cycle; next state MEM_WAIT; wait counter := 1.
  - RUN, mem_req=1 and mem_ready=1: single-cycle access; no freeze; stay in RUN.
  - MEM_WAIT, mem_ready=0: `freeze_pipe`=1; wait counter +1 (saturating).
  - MEM_WAIT, mem_ready=1: `freeze_pipe`=0 this cycle; next state RUN; wait counter := 0.
  - `mem_req` is ignored in MEM_WAIT (the MEM instruction is held).
- Priority (combinational, in this order):
  1. `freeze_pipe`=1 → `freeze_PC`, `freeze_IF_ID`, `flush_IF_ID` and `bubble_ID_EXE` all 0. The held registers re-present the hazard/branch condition after release.
  2. Else `hazard_detected`=1 → `freeze_PC`=1, `freeze_IF_ID`=1, `bubble_ID_EXE`=1, `flush_IF_ID`=0. `branch_taken` is ignored because the branch operands are not valid.
  3. Else `branch_taken`=1 → `flush_IF_ID`=1 for exactly that cycle; no freeze, no bubble.
  4. Else all 0.
- Stall watchdog:
  - Stall-run counter increments on each cycle `bubble_ID_EXE`=1 and clears on any cycle where it is 0 and `freeze_pipe`=0.
  - `freeze_pipe` cycles hold the counter.
  - When the counter reaches MAX_STALL, `stall_error` sets on that edge and stays set until reset or `cnt_clr`.
- Memory timeout: wait counter reaching MEM_TIMEOUT sets `mem_timeout` (sticky). The controller keeps waiting; there is no forced release.
- Performance counters: increment by 1 on the edge after a qualifying cycle; saturate at 2^CNT_W−1, with no wrap-around.
- `cnt_clr`=1:
  - On the next edge, counters and sticky flags go to 0.
  - `cnt_clr` has priority over an increment in the same cycle.
  - It does not affect state, the wait counter or the stall-run counter.
- Reset during MEM_WAIT: immediately returns to RUN, with all outputs 0.

Test Plan:
- Reset, then idle with all inputs 0 → all outputs 0, counters 0.
- `hazard_detected`=1 for 3 cycles → `freeze_PC`, `freeze_IF_ID` and `bubble_ID_EXE` high for 3 cycles; `stall_count`=3; `stall_error`=0.
- `hazard_detected`=1 and `branch_taken`=1 together → stall outputs high, `flush_IF_ID`=0. Then hazard=0 with branch=1 → `flush_IF_ID`=1 for one cycle; `flush_count`=1.
- `mem_req`=1, with `mem_ready` rising 4 cycles later → `freeze_pipe` high for 4 cycles, low in the ready cycle; `wait_count`=4. During the wait, `hazard_detected`=1 gives `bubble_ID_EXE`=0.
- `hazard_detected` held for 8 cycles → `stall_error`=1 after the 8th edge and still 1 after hazard drops. Then `cnt_clr` → `stall_error`=0 and `stall_count`=0.
- CNT_W=4 with 20 stall cycles → `stall_count` saturates at 15.
- `mem_ready` held 0 for 70 cycles → `mem_timeout`=1 at wait 64. Asserting rst_n=0 mid-wait → `freeze_pipe`=0 immediately.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Stall/flush controller for a 5-stage pipeline: per-stage controls are combinational (same cycle),
// SRAM-wait FSM, stall watchdog, memory timeout and saturating perf counters update on the next edge.
module pipeline_stall_controller #(
  parameter int CNT_W       = 16,
  parameter int MAX_STALL   = 8,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             freeze_PC,
  output logic             freeze_IF_ID,
  output logic             flush_IF_ID,
  output logic             bubble_ID_EXE,
  output logic             freeze_pipe,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] wait_count,
  output logic             stall_error,
  output logic             mem_timeout
);

  localparam int RUN_W  = $clog2(MAX_STALL + 1);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [0:0] {ST_RUN, ST_MEM_WAIT} state_t;

  state_t              r_state, w_state_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt, w_wait_nxt;
  logic [RUN_W-1:0]    r_run_cnt, w_run_nxt;
  logic [CNT_W-1:0]    r_stall_count, r_flush_count, r_wait_count;
  logic                r_stall_error, r_mem_timeout;
  logic                w_freeze_raw, w_freeze, w_stall, w_flush;
  logic                w_stall_hit, w_tmo_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    w_state_nxt  = r_state;
    w_wait_nxt   = r_wait_cnt;
    w_freeze_raw = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          w_freeze_raw = 1'b1;
          w_state_nxt  = ST_MEM_WAIT;
          w_wait_nxt   = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        // mem_req is ignored here: the MEM instruction is being held
        if (mem_ready) begin
          w_state_nxt = ST_RUN;
          w_wait_nxt  = '0;
        end else begin
          w_freeze_raw = 1'b1;
          if (r_wait_cnt != {WAIT_W{1'b1}}) w_wait_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // rst_n gating keeps every control low while reset is held, whatever the inputs
  assign w_freeze = rst_n && w_freeze_raw;
  assign w_stall  = rst_n && !w_freeze && hazard_detected;
  assign w_flush  = rst_n && !w_freeze && !hazard_detected && branch_taken;

  always_comb begin
    w_run_nxt = r_run_cnt;
    if (w_stall) begin
      if (r_run_cnt != {RUN_W{1'b1}}) w_run_nxt = r_run_cnt + RUN_W'(1);
    end else if (!w_freeze) begin
      w_run_nxt = '0;
    end
  end

  assign w_stall_hit = (w_run_nxt == RUN_W'(MAX_STALL)) && (r_run_cnt != RUN_W'(MAX_STALL));
  assign w_tmo_hit   = (w_wait_nxt == WAIT_W'(MEM_TIMEOUT)) && (r_wait_cnt != WAIT_W'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_run_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_run_cnt  <= w_run_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
      r_wait_count  <= '0;
      r_stall_error <= 1'b0;
      r_mem_timeout <= 1'b0;
    end else if (cnt_clr) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
      r_wait_count  <= '0;
      r_stall_error <= 1'b0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_stall_count <= sat_inc(r_stall_count, w_stall);
      r_flush_count <= sat_inc(r_flush_count, w_flush);
      r_wait_count  <= sat_inc(r_wait_count, w_freeze);
      if (w_stall_hit) r_stall_error <= 1'b1;
      if (w_tmo_hit)   r_mem_timeout <= 1'b1;
    end
  end

  assign freeze_pipe   = w_freeze;
  assign freeze_PC     = w_stall;
  assign freeze_IF_ID  = w_stall;
  assign bubble_ID_EXE = w_stall;
  assign flush_IF_ID   = w_flush;
  assign stall_count   = r_stall_count;
  assign flush_count   = r_flush_count;
  assign wait_count    = r_wait_count;
  assign stall_error   = r_stall_error;
  assign mem_timeout   = r_mem_timeout;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench: expected control vectors queued at drive time, compared mid-cycle.
module tb_pipeline_stall_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hazard_detected, branch_taken, mem_req, mem_ready, cnt_clr;
  logic        freeze_PC, freeze_IF_ID, flush_IF_ID, bubble_ID_EXE, freeze_pipe;
  logic [15:0] stall_count, flush_count, wait_count;
  logic        stall_error, mem_timeout;

  logic        b_freeze_PC, b_freeze_IF_ID, b_flush_IF_ID, b_bubble_ID_EXE, b_freeze_pipe;
  logic [3:0]  b_stall_count, b_flush_count, b_wait_count;
  logic        b_stall_error, b_mem_timeout;

  int checks   = 0;
  int failures = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  pipeline_stall_controller dut (
    .clk(clk), .rst_n(rst_n),
    .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .freeze_PC(freeze_PC), .freeze_IF_ID(freeze_IF_ID), .flush_IF_ID(flush_IF_ID),
    .bubble_ID_EXE(bubble_ID_EXE), .freeze_pipe(freeze_pipe),
    .stall_count(stall_count), .flush_count(flush_count), .wait_count(wait_count),
    .stall_error(stall_error), .mem_timeout(mem_timeout)
  );

  // Narrow-counter instance, never cleared, used for saturation
  pipeline_stall_controller #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(1'b0),
    .freeze_PC(b_freeze_PC), .freeze_IF_ID(b_freeze_IF_ID), .flush_IF_ID(b_flush_IF_ID),
    .bubble_ID_EXE(b_bubble_ID_EXE), .freeze_pipe(b_freeze_pipe),
    .stall_count(b_stall_count), .flush_count(b_flush_count), .wait_count(b_wait_count),
    .stall_error(b_stall_error), .mem_timeout(b_mem_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs driven just after posedge; expected {fPC,fIFID,flush,bubble,fpipe} checked at negedge
  task automatic cyc(input logic h, input logic b, input logic rq, input logic rd,
                     input logic cl, input logic [4:0] exp, input string tag);
    logic [4:0] e;
    hazard_detected = h;
    branch_taken    = b;
    mem_req         = rq;
    mem_ready       = rd;
    cnt_clr         = cl;
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    chk(tag, {27'd0, freeze_PC, freeze_IF_ID, flush_IF_ID, bubble_ID_EXE, freeze_pipe}, {27'd0, e});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    hazard_detected = 1'b1; branch_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0; cnt_clr = 1'b0;
    #2;
    chk("rst_ctrl", {27'd0, freeze_PC, freeze_IF_ID, flush_IF_ID, bubble_ID_EXE, freeze_pipe}, 32'd0);
    chk("rst_cnt", {stall_count, flush_count}, 32'd0);
    chk("rst_flags", {30'd0, stall_error, mem_timeout}, 32'd0);
    hazard_detected = 1'b0; branch_taken = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0, 5'b00000, "idle");
    chk("idle_cnt", {stall_count, wait_count}, 32'd0);

    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 5'b11010, "hz3");
    chk("hz3_count", stall_count, 32'd3);
    chk("hz3_err", stall_error, 32'd0);
    cyc(0, 0, 0, 0, 0, 5'b00000, "hz3_idle");

    cyc(1, 1, 0, 0, 0, 5'b11010, "hz_br");
    cyc(0, 1, 0, 0, 0, 5'b00100, "br_only");
    cyc(0, 0, 0, 0, 0, 5'b00000, "br_idle");
    chk("flush_count", flush_count, 32'd1);
    chk("stall_after_br", stall_count, 32'd4);

    cyc(0, 0, 1, 0, 0, 5'b00001, "mw_enter");
    cyc(0, 0, 1, 0, 0, 5'b00001, "mw1");
    cyc(1, 0, 1, 0, 0, 5'b00001, "mw_hazard");
    cyc(0, 0, 1, 0, 0, 5'b00001, "mw3");
    cyc(0, 0, 1, 1, 0, 5'b00000, "mw_ready");
    chk("wait_count", wait_count, 32'd4);
    chk("stall_during_mw", stall_count, 32'd4);
    cyc(0, 0, 0, 0, 0, 5'b00000, "post_mw");
    cyc(0, 0, 1, 1, 0, 5'b00000, "mem_1cyc");
    cyc(0, 0, 0, 0, 0, 5'b00000, "post_1cyc");
    chk("wait_1cyc", wait_count, 32'd4);

    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0, 5'b11010, "hz8");
    chk("wd_before", stall_error, 32'd0);
    cyc(1, 0, 0, 0, 0, 5'b11010, "hz8_last");
    chk("wd_trip", stall_error, 32'd1);
    chk("stall_12", stall_count, 32'd12);
    cyc(0, 0, 0, 0, 0, 5'b00000, "wd_idle");
    chk("wd_sticky", stall_error, 32'd1);
    cyc(1, 0, 0, 0, 1, 5'b11010, "clr_hz");
    chk("clr_err", stall_error, 32'd0);
    chk("clr_prio", stall_count, 32'd0);
    chk("clr_cnts", {flush_count, wait_count}, 32'd0);
    chk("sat_pre", b_stall_count, 32'd13);
    cyc(0, 0, 0, 0, 0, 5'b00000, "clr_idle");

    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 0, 5'b11010, "hz20");
    chk("sat15", b_stall_count, 32'd15);
    chk("stall_20", stall_count, 32'd20);
    chk("wd_again", stall_error, 32'd1);
    cyc(0, 0, 0, 0, 0, 5'b00000, "hz20_idle");
    cyc(0, 0, 0, 0, 1, 5'b00000, "clr2");
    chk("clr2_err", stall_error, 32'd0);

    for (int i = 0; i < 63; i++) cyc(0, 0, 1, 0, 0, 5'b00001, "tmo_wait");
    chk("tmo_before", mem_timeout, 32'd0);
    chk("wait_63", wait_count, 32'd63);
    cyc(0, 0, 1, 0, 0, 5'b00001, "tmo_64");
    chk("tmo_set", mem_timeout, 32'd1);
    chk("wait_64", wait_count, 32'd64);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0, 5'b00001, "tmo_hold");
    chk("tmo_sticky", mem_timeout, 32'd1);
    chk("wait_70", wait_count, 32'd70);

    hazard_detected = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", {27'd0, freeze_PC, freeze_IF_ID, flush_IF_ID, bubble_ID_EXE, freeze_pipe}, 32'd0);
    chk("rst_mid_flags", {30'd0, stall_error, mem_timeout}, 32'd0);
    chk("rst_mid_cnt", wait_count, 32'd0);
    hazard_detected = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0, 5'b00000, "post_rst_run");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
